// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: operand forwarding,
// load-use and branch stall/flush, and data-memory wait tracking with timeout.
module hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             LoadE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  state_t     state, state_nx;
  logic [7:0] wait_cnt, wait_cnt_nx;
  logic       lw, lw_stall, mem_stall;

  // Memory-stage match wins over Writeback; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rdm,
                                         input logic wem, input logic [4:0] rdw,
                                         input logic wew);
    if (rs != 5'd0 && wem && rs == rdm) return 2'b10;
    if (rs != 5'd0 && wew && rs == rdw) return 2'b01;
    return 2'b00;
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    unique case (state)
      RUN: begin
        if (MemReqM && !MemReadyM) begin
          state_nx    = MEM_WAIT;
          wait_cnt_nx = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (MemReadyM)                            state_nx = RUN;
        else if (wait_cnt == 8'(TIMEOUT - 1))     state_nx = ERR;
        else                                      wait_cnt_nx = wait_cnt + 8'd1;
      end
      ERR:     state_nx = ERR;
      default: state_nx = RUN;
    endcase
  end

  assign lw        = LoadE && (Rs1D == RdE || Rs2D == RdE) && RdE != 5'd0;
  assign lw_stall  = lw && !PCSrcE;
  assign mem_stall = (state == RUN && MemReqM && !MemReadyM) || state == MEM_WAIT
                     || state == ERR;

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    if (!reset) begin
      ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
      if (mem_stall) begin
        // Execute is frozen, so branch/load-use effects resurface on release.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF = lw_stall;
        StallD = lw_stall;
        FlushE = lw_stall || PCSrcE;
        FlushD = PCSrcE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      wait_cnt     <= 8'd0;
      mem_err      <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      mem_err  <= mem_err || (state == ERR);
      if (StallF && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: table of combinational vectors plus
// hand-written memory-wait, branch-during-wait, timeout and saturation sequences.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
  logic [3:0] stall_cycles;
  logic [6:0] ctl;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] MEMSTALL = 7'b1111100;

  hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // {StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE}
  assign ctl = {StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE};

  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       wem, wew, loade, pcsrce;
    logic [1:0] fa, fb;
    logic       stall, fd, fe;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
                              input logic wem, wew, loade, pcsrce,
                              input logic [1:0] fa, fb, input logic stall, fd, fe);
    vec_t v;
    v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
    v.rde = rde; v.rdm = rdm; v.rdw = rdw;
    v.wem = wem; v.wew = wew; v.loade = loade; v.pcsrce = pcsrce;
    v.fa = fa; v.fb = fb; v.stall = stall; v.fd = fd; v.fe = fe;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM} = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;

    // Reset dominates: hazard-provoking inputs must not leak to the outputs.
    Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1; Rs2E = 5'd6; RdW = 5'd6; RegWriteW = 1'b1;
    LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7; PCSrcE = 1'b1; MemReqM = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_ctl", 32'(ctl), 32'd0);
    check("reset_fwd", 32'({ForwardAE, ForwardBE}), 32'd0);
    check("reset_memerr", 32'(mem_err), 32'd0);
    check("reset_cnt", 32'(stall_cycles), 32'd0);

    //            rs1d rs2d rs1e rs2e rde rdm rdw wem wew ld br  fa     fb    st fd fe
    vecs[0]  = mk(0,   0,   5,   0,   0,  5,  5,  1,  1,  0, 0, 2'b10, 2'b00, 0, 0, 0);
    vecs[1]  = mk(0,   0,   0,   0,   0,  0,  0,  1,  1,  0, 0, 2'b00, 2'b00, 0, 0, 0);
    vecs[2]  = mk(0,   0,   5,   6,   0,  6,  5,  1,  1,  0, 0, 2'b01, 2'b10, 0, 0, 0);
    vecs[3]  = mk(0,   0,   5,   5,   0,  5,  5,  0,  1,  0, 0, 2'b01, 2'b01, 0, 0, 0);
    vecs[4]  = mk(0,   0,   4,   3,   0,  3,  4,  1,  0,  0, 0, 2'b00, 2'b10, 0, 0, 0);
    vecs[5]  = mk(0,   7,   0,   0,   7,  0,  0,  0,  0,  1, 0, 2'b00, 2'b00, 1, 0, 1);
    vecs[6]  = mk(0,   7,   0,   0,   7,  0,  0,  0,  0,  1, 1, 2'b00, 2'b00, 0, 1, 1);
    vecs[7]  = mk(0,   0,   0,   0,   0,  0,  0,  0,  0,  1, 0, 2'b00, 2'b00, 0, 0, 0);
    vecs[8]  = mk(7,   0,   0,   0,   7,  0,  0,  0,  0,  0, 0, 2'b00, 2'b00, 0, 0, 0);
    vecs[9]  = mk(0,   0,   0,   0,   0,  0,  0,  0,  0,  0, 1, 2'b00, 2'b00, 0, 1, 1);
    vecs[10] = mk(9,   3,   0,   0,   9,  0,  0,  0,  0,  1, 0, 2'b00, 2'b00, 1, 0, 1);

    do_reset();
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e;
      RdE = vecs[i].rde; RdM = vecs[i].rdm; RdW = vecs[i].rdw;
      RegWriteM = vecs[i].wem; RegWriteW = vecs[i].wew;
      LoadE = vecs[i].loade; PCSrcE = vecs[i].pcsrce;
      #1;
      check($sformatf("vec%0d_fwda", i), 32'(ForwardAE), 32'(vecs[i].fa));
      check($sformatf("vec%0d_fwdb", i), 32'(ForwardBE), 32'(vecs[i].fb));
      check($sformatf("vec%0d_ctl", i), 32'(ctl),
            32'({vecs[i].stall, vecs[i].stall, 3'b000, vecs[i].fd, vecs[i].fe}));
    end

    // Load-use for one cycle bumps the counter by exactly one.
    do_reset();
    @(negedge clk);
    LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    #1 check("lu_ctl", 32'(ctl), 32'b1100001);
    @(negedge clk);
    clear_inputs();
    #1;
    check("lu_release", 32'(ctl), 32'd0);
    check("lu_cnt", 32'(stall_cycles), 32'd1);

    // Three-cycle memory wait: four stalled cycles, release with ready in MEM_WAIT.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      MemReqM = 1'b1; MemReadyM = (k == 3);
      #1 check($sformatf("mw_stall%0d", k), 32'(ctl), 32'(MEMSTALL));
    end
    @(negedge clk);
    MemReqM = 1'b0; MemReadyM = 1'b0;
    #1;
    check("mw_release", 32'(ctl), 32'd0);
    check("mw_cnt", 32'(stall_cycles), 32'd4);

    // Zero-wait access causes no stall and leaves the FSM in RUN.
    @(negedge clk);
    MemReqM = 1'b1; MemReadyM = 1'b1;
    #1 check("zw_ctl", 32'(ctl), 32'd0);
    @(negedge clk);
    MemReqM = 1'b0; MemReadyM = 1'b0;
    #1 check("zw_after", 32'(ctl), 32'd0);

    // Taken branch during a two-cycle wait is deferred until after release.
    do_reset();
    @(negedge clk);
    PCSrcE = 1'b1; MemReqM = 1'b1; MemReadyM = 1'b0;
    #1 check("br_wait0", 32'(ctl), 32'(MEMSTALL));
    @(negedge clk);
    MemReadyM = 1'b1;
    #1 check("br_wait1", 32'(ctl), 32'(MEMSTALL));
    @(negedge clk);
    MemReqM = 1'b0; MemReadyM = 1'b0;
    #1 check("br_release", 32'(ctl), 32'b0000011);

    // Timeout into ERR with saturating counter, then asynchronous reset.
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      MemReqM = 1'b1; MemReadyM = 1'b0;
      #1;
      check($sformatf("to_stall%0d", k), 32'(ctl), 32'(MEMSTALL));
      check($sformatf("to_cnt%0d", k), 32'(stall_cycles), (k - 1 > 15) ? 32'd15 : 32'(k - 1));
      if (k == 5) check("to_memerr_entry", 32'(mem_err), 32'd0);
      if (k == 6) check("to_memerr_set", 32'(mem_err), 32'd1);
    end
    @(negedge clk);
    MemReqM = 1'b0; MemReadyM = 1'b1;
    #1;
    check("err_sticky_ctl", 32'(ctl), 32'(MEMSTALL));
    check("err_sat_cnt", 32'(stall_cycles), 32'd15);
    @(negedge clk);
    #1 check("err_sticky_flag", 32'(mem_err), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_ctl", 32'(ctl), 32'd0);
    check("async_rst_memerr", 32'(mem_err), 32'd0);
    check("async_rst_cnt", 32'(stall_cycles), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    MemReqM = 1'b0; MemReadyM = 1'b0;
    #1 check("post_rst_run", 32'(ctl), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
